// File: rtl/timestamp_reader_pkg.sv
// Shared types and default parameters for the timestamper host-side reader.
package timestamp_reader_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SCLK_DIV    = 2;
  localparam int DEF_RSTCAPT_LEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    ARM,
    WAIT_CLR
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit CPLD status lines.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/timestamp_reader.sv
// Reads the timestamper's captured count over CE_N/SCLK/SDO when INT is seen,
// offers it on a valid/ready port and re-arms capture with an RSTCAPT pulse.
module timestamp_reader
  import timestamp_reader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SCLK_DIV    = DEF_SCLK_DIV,
  parameter int RSTCAPT_LEN = DEF_RSTCAPT_LEN
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             INT,
  input  logic             SDO,
  output logic             SCLK,
  output logic             CE_N,
  output logic             RSTCAPT,
  output logic [WIDTH-1:0] TS_DATA,
  output logic             TS_VALID,
  input  logic             TS_READY,
  output logic             BUSY
);

  localparam int BIT_W = $clog2(WIDTH) + 1;
  localparam int DIV_W = $clog2(SCLK_DIV) + 1;
  localparam int ARM_W = $clog2(RSTCAPT_LEN) + 1;

  localparam logic [BIT_W-1:0] BITS_DONE = BIT_W'(WIDTH);
  localparam logic [DIV_W-1:0] DIV_END   = DIV_W'(SCLK_DIV - 1);
  localparam logic [ARM_W-1:0] ARM_END   = ARM_W'(RSTCAPT_LEN - 1);

  state_t             state, state_d;
  logic [DIV_W-1:0]   div_cnt, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [ARM_W-1:0]   arm_cnt, arm_cnt_d;
  logic [WIDTH-1:0]   sr, sr_d;
  logic [WIDTH-1:0]   ts_data_d;
  logic               sclk_d, ce_n_d, rstcapt_d, ts_valid_d;
  logic               int_s;

  sync2 u_int_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (INT),
    .q     (int_s)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      arm_cnt  <= '0;
      sr       <= '0;
      SCLK     <= 1'b0;
      CE_N     <= 1'b1;
      RSTCAPT  <= 1'b0;
      TS_DATA  <= '0;
      TS_VALID <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      arm_cnt  <= arm_cnt_d;
      sr       <= sr_d;
      SCLK     <= sclk_d;
      CE_N     <= ce_n_d;
      RSTCAPT  <= rstcapt_d;
      TS_DATA  <= ts_data_d;
      TS_VALID <= ts_valid_d;
    end
  end

  // A delivered word can be consumed in any state; the end of SHIFT overrides
  // the clear, which is safe because a transfer only starts with TS_VALID low.
  always_comb begin
    state_d    = state;
    div_cnt_d  = div_cnt;
    bit_cnt_d  = bit_cnt;
    arm_cnt_d  = arm_cnt;
    sr_d       = sr;
    sclk_d     = SCLK;
    ce_n_d     = CE_N;
    rstcapt_d  = RSTCAPT;
    ts_data_d  = TS_DATA;
    ts_valid_d = TS_VALID && !TS_READY;

    case (state)
      IDLE: begin
        if (int_s && ENABLE && !TS_VALID) begin
          state_d   = SETUP;
          ce_n_d    = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      SETUP: begin
        if (div_cnt == DIV_END) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + DIV_W'(1);
        end
      end

      // Sample on the low-to-high SCLK step; finish on the following fall.
      SHIFT: begin
        if (div_cnt != DIV_END) begin
          div_cnt_d = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          if (!SCLK) begin
            sclk_d    = 1'b1;
            sr_d      = sr << 1;
            sr_d[0]   = SDO;
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == BITS_DONE) begin
              ce_n_d     = 1'b1;
              ts_data_d  = sr;
              ts_valid_d = 1'b1;
              state_d    = HOLD;
            end
          end
        end
      end

      HOLD: begin
        state_d   = ARM;
        rstcapt_d = 1'b1;
        arm_cnt_d = '0;
      end

      ARM: begin
        if (arm_cnt == ARM_END) begin
          rstcapt_d = 1'b0;
          state_d   = WAIT_CLR;
        end else begin
          arm_cnt_d = arm_cnt + ARM_W'(1);
        end
      end

      // INT lags RSTCAPT through the synchronizer; wait for it to clear.
      WAIT_CLR: begin
        if (!int_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_timestamp_reader.sv
// Directed bench: behavioural timestamper SPI slaves driving an 8-bit default
// reader and a 12-bit, SCLK_DIV=3 reader.
module tb_timestamp_reader;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b1;
  logic        int_req  = 1'b0;
  logic        ts_ready = 1'b0;
  logic        sdo, sclk, ce_n, rstcapt, ts_valid, busy;
  logic [7:0]  ts_data;

  logic        int_req2  = 1'b0;
  logic        sdo2, sclk2, ce_n2, rstcapt2, ts_valid2, busy2;
  logic [11:0] ts_data2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mval  = 8'h00;
  logic [11:0] mval2 = 12'h000;
  logic [7:0]  sh;
  logic [11:0] sh2;
  int bidx  = 0;
  int bidx2 = 0;
  int sclk_rises    = 0;
  int sclk2_rises   = 0;
  int rstcapt_rises = 0;

  always #5 clk = ~clk;

  timestamp_reader #(.WIDTH(8), .SCLK_DIV(2), .RSTCAPT_LEN(2)) u_dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .INT(int_req), .SDO(sdo),
    .SCLK(sclk), .CE_N(ce_n), .RSTCAPT(rstcapt), .TS_DATA(ts_data),
    .TS_VALID(ts_valid), .TS_READY(ts_ready), .BUSY(busy)
  );

  timestamp_reader #(.WIDTH(12), .SCLK_DIV(3), .RSTCAPT_LEN(2)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .ENABLE(1'b1), .INT(int_req2), .SDO(sdo2),
    .SCLK(sclk2), .CE_N(ce_n2), .RSTCAPT(rstcapt2), .TS_DATA(ts_data2),
    .TS_VALID(ts_valid2), .TS_READY(1'b0), .BUSY(busy2)
  );

  // Timestamper slaves: MSB valid at CE_N fall, next bit after each SCLK fall.
  always @(negedge sclk or posedge ce_n) begin
    if (ce_n) bidx <= 0;
    else      bidx <= bidx + 1;
  end
  assign sh  = mval << bidx;
  assign sdo = sh[7];

  always @(negedge sclk2 or posedge ce_n2) begin
    if (ce_n2) bidx2 <= 0;
    else       bidx2 <= bidx2 + 1;
  end
  assign sh2  = mval2 << bidx2;
  assign sdo2 = sh2[11];

  always @(posedge sclk)    sclk_rises++;
  always @(posedge sclk2)   sclk2_rises++;
  always @(posedge rstcapt) rstcapt_rises++;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task tick;
    @(negedge clk);
  endtask

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task applyStimulus(input logic en, input logic irq, input logic rdy);
    enable   = en;
    int_req  = irq;
    ts_ready = rdy;
  endtask

  task automatic wait_ce(input logic lvl, input string tag);
    int n = 0;
    while (ce_n !== lvl && n < 300) begin
      tick;
      n++;
    end
    checkOutput(tag, ce_n, lvl);
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (ce_n === 1'b0 && n < 300) begin
      n++;
      tick;
    end
  endtask

  task automatic wait_rstcapt(input string tag);
    int n = 0;
    while (rstcapt !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    checkOutput({tag, "_rise"}, rstcapt, 1'b1);
    n = 0;
    while (rstcapt !== 1'b0 && n < 50) begin
      tick;
      n++;
    end
    checkOutput({tag, "_fall"}, rstcapt, 1'b0);
  endtask

  task release_int;
    int_req = 1'b0;
    repeat (4) tick;
    ts_ready = 1'b1;
    tick;
    ts_ready = 1'b0;
  endtask

  initial begin
    int n, r0, rc0, cnt, hi, run, bad;

    repeat (3) tick;
    checkOutput("rst_ce_n", ce_n, 1'b1);
    checkOutput("rst_sclk", sclk, 1'b0);
    checkOutput("rst_rstcapt", rstcapt, 1'b0);
    checkOutput("rst_ts_data", ts_data, 8'h00);
    checkOutput("rst_ts_valid", ts_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ce_n2", ce_n2, 1'b1);
    rst_n = 1'b1;
    repeat (2) tick;

    // Basic read: latency, length, bit count, data, RSTCAPT pulse
    mval = 8'h0A;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) tick;
    checkOutput("t1_ce_before_k2", ce_n, 1'b1);
    tick;
    checkOutput("t1_ce_after_k2", ce_n, 1'b0);
    checkOutput("t1_busy", busy, 1'b1);
    r0 = sclk_rises;
    measure_low(n);
    checkOutput("t1_ce_low_cycles", n, 34);
    checkOutput("t1_sclk_rises", sclk_rises - r0, 8);
    checkOutput("t1_data", ts_data, 8'h0A);
    checkOutput("t1_valid", ts_valid, 1'b1);
    checkOutput("t1_sclk_idle", sclk, 1'b0);
    checkOutput("t1_hold_rstcapt", rstcapt, 1'b0);
    tick;
    checkOutput("t1_rstcapt_c1", rstcapt, 1'b1);
    tick;
    checkOutput("t1_rstcapt_c2", rstcapt, 1'b1);
    tick;
    checkOutput("t1_rstcapt_end", rstcapt, 1'b0);
    checkOutput("t1_wait_clr_busy", busy, 1'b1);
    release_int;
    checkOutput("t1_consumed", ts_valid, 1'b0);
    checkOutput("t1_idle", busy, 1'b0);

    // Backpressure: unconsumed word blocks the next transfer
    mval = 8'hA5;
    applyStimulus(1'b1, 1'b1, 1'b0);
    wait_ce(1'b0, "t2_start");
    measure_low(n);
    checkOutput("t2_ce_low_cycles", n, 34);
    checkOutput("t2_data", ts_data, 8'hA5);
    wait_rstcapt("t2_rstcapt");
    int_req = 1'b0;
    repeat (4) tick;
    mval = 8'h3C;
    int_req = 1'b1;
    cnt = 0;
    repeat (100) begin
      tick;
      if (ce_n !== 1'b1) cnt++;
    end
    checkOutput("t2_no_ce_activity", cnt, 0);
    checkOutput("t2_data_stable", ts_data, 8'hA5);
    checkOutput("t2_valid_held", ts_valid, 1'b1);
    checkOutput("t2_busy_idle", busy, 1'b0);
    ts_ready = 1'b1;
    tick;
    ts_ready = 1'b0;
    checkOutput("t2_valid_drop", ts_valid, 1'b0);
    wait_ce(1'b0, "t2_second_start");
    measure_low(n);
    checkOutput("t2_second_cycles", n, 34);
    checkOutput("t2_second_data", ts_data, 8'h3C);
    wait_rstcapt("t2_second_rstcapt");
    release_int;

    // Async reset after the third SCLK rise
    mval = 8'h5A;
    applyStimulus(1'b1, 1'b1, 1'b0);
    wait_ce(1'b0, "t3_start");
    r0 = sclk_rises;
    n = 0;
    while (sclk_rises - r0 < 3 && n < 100) begin
      tick;
      n++;
    end
    checkOutput("t3_three_rises", sclk_rises - r0, 3);
    rc0 = rstcapt_rises;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t3_async_ce_n", ce_n, 1'b1);
    checkOutput("t3_async_sclk", sclk, 1'b0);
    checkOutput("t3_async_valid", ts_valid, 1'b0);
    checkOutput("t3_async_busy", busy, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
    wait_ce(1'b0, "t3_restart");
    checkOutput("t3_no_rstcapt", rstcapt_rises - rc0, 0);
    measure_low(n);
    checkOutput("t3_cycles", n, 34);
    checkOutput("t3_data", ts_data, 8'h5A);
    wait_rstcapt("t3_rstcapt");
    release_int;

    // ENABLE gating, then ENABLE dropped mid-SHIFT
    mval = 8'h81;
    applyStimulus(1'b0, 1'b1, 1'b0);
    cnt = 0;
    repeat (10) begin
      tick;
      if (ce_n !== 1'b1 || busy !== 1'b0) cnt++;
    end
    checkOutput("t4_disabled_idle", cnt, 0);
    enable = 1'b1;
    wait_ce(1'b0, "t4_start");
    r0 = sclk_rises;
    n = 0;
    while (sclk_rises - r0 < 2 && n < 100) begin
      tick;
      n++;
    end
    enable = 1'b0;
    wait_ce(1'b1, "t4_done");
    checkOutput("t4_data", ts_data, 8'h81);
    checkOutput("t4_valid", ts_valid, 1'b1);
    wait_rstcapt("t4_rstcapt");
    enable = 1'b1;
    release_int;

    // Ready already high when the word lands; INT lingers after RSTCAPT
    mval = 8'h66;
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_ce(1'b0, "t5_start");
    measure_low(n);
    checkOutput("t5_ready_same_cycle", ts_valid, 1'b1);
    checkOutput("t5_data", ts_data, 8'h66);
    tick;
    checkOutput("t5_consumed_next", ts_valid, 1'b0);
    ts_ready = 1'b0;
    wait_rstcapt("t5_rstcapt");
    cnt = 0;
    repeat (5) begin
      tick;
      if (ce_n !== 1'b1 || busy !== 1'b1) cnt++;
    end
    checkOutput("t5_wait_clr_hold", cnt, 0);
    int_req = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick;
      if (ce_n !== 1'b1) cnt++;
    end
    checkOutput("t5_no_second_read", cnt, 0);
    checkOutput("t5_idle", busy, 1'b0);
    mval = 8'h09;
    int_req = 1'b1;
    wait_ce(1'b0, "t5_reread_start");
    measure_low(n);
    checkOutput("t5_reread_data", ts_data, 8'h09);
    wait_rstcapt("t5_reread_rstcapt");
    release_int;

    // WIDTH=12, SCLK_DIV=3 instance
    mval2 = 12'hABC;
    int_req2 = 1'b1;
    n = 0;
    while (ce_n2 !== 1'b0 && n < 50) begin
      tick;
      n++;
    end
    checkOutput("t6_start", ce_n2, 1'b0);
    r0 = sclk2_rises;
    n = 0; hi = 0; run = 0; bad = 0;
    while (ce_n2 === 1'b0 && n < 500) begin
      n++;
      if (sclk2 === 1'b1) begin
        hi++;
        run++;
      end else if (run != 0) begin
        if (run != 3) bad++;
        run = 0;
      end
      tick;
    end
    if (run != 3) bad++;
    checkOutput("t6_ce_low_cycles", n, 75);
    checkOutput("t6_sclk_high_cycles", hi, 36);
    checkOutput("t6_sclk_low_cycles", n - hi, 39);
    checkOutput("t6_high_run_len", bad, 0);
    checkOutput("t6_sclk_rises", sclk2_rises - r0, 12);
    checkOutput("t6_data", ts_data2, 12'hABC);
    checkOutput("t6_valid", ts_valid2, 1'b1);
    int_req2 = 1'b0;
    repeat (10) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timestamp_reader.md
Name: timestamp_reader

Overview:
Host-side reader for the timestamper CPLD. Waits for the CPLD's INT flag, reads the captured count over the 3-wire SPI link (CE_N/SCLK/SDO), and presents it on a valid/ready output port. Pulses RSTCAPT to re-arm capture once the word is held locally. It sits directly downstream of the timestamper and drives all of that block's SPI and RSTCAPT inputs.

Parameters:
WIDTH, 8, captured count width in bits; bits shifted per transfer.
SCLK_DIV, 2, SCLK half-period in CLK cycles; legal values ≥2.
RSTCAPT_LEN, 2, RSTCAPT high time in CLK cycles; legal values ≥1.

Ports:
CLK  in  1  system clock; one clock domain.
RST_N  in  1  asynchronous, active-low reset.
ENABLE  in  1  when low, no new transfer starts.
INT  in  1  from timestamper; high means a capture is latched. Asynchronous to CLK.
SDO  in  1  serial data from timestamper, MSB first.
SCLK  out  1  SPI clock; idles low.
CE_N  out  1  SPI chip enable, active low.
RSTCAPT  out  1  re-arm pulse to timestamper.
TS_DATA  out  WIDTH  last captured count.
TS_VALID  out  1  TS_DATA holds an unconsumed word.
TS_READY  in  1  consumer accepts the word when TS_VALID && TS_READY.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, while RST_N=0): SCLK=0, CE_N=1, RSTCAPT=0, TS_DATA=0, TS_VALID=0, BUSY=0, state=IDLE, synchronizer flops=0.
- INT passes through a 2-flop synchronizer to give int_s. SDO is not synchronized; its timing is guaranteed by SCLK_DIV ≥2.
- SPI protocol:
  - Timestamper updates SDO on SCLK falling edge; first bit is valid once CE_N is low.
  - Reader samples SDO on the CLK edge where registered SCLK goes 0→1.
  - Bits are shifted MSB first into shift register sr.
- States: IDLE, SETUP, SHIFT, HOLD, ARM, WAIT_CLR.
- IDLE → SETUP when int_s && ENABLE && !TS_VALID. CE_N goes low on that edge.
  - Latency: INT rising before edge k gives CE_N low after edge k+2.
- SETUP: hold SCLK low for SCLK_DIV cycles, then enter SHIFT.
- SHIFT:
  - SCLK toggles every SCLK_DIV cycles. Each bit takes 2*SCLK_DIV cycles, low half first.
  - bit_cnt counts 0..WIDTH-1 and increments at each sample.
  - At the falling edge after the last sample, SCLK=0 and CE_N=1.
  - On that same edge: TS_DATA<=sr, TS_VALID<=1, go to HOLD.
- HOLD: one cycle with CE_N high, then ARM.
- ARM: RSTCAPT=1 for exactly RSTCAPT_LEN cycles, then WAIT_CLR.
- WAIT_CLR: stay until int_s==0, then IDLE. This prevents re-reading a stale INT through synchronizer latency.
- Output handshake:
  - TS_VALID clears on the edge where TS_VALID && TS_READY, in any state.
  - TS_DATA is stable while TS_VALID=1.
- Backpressure: when TS_VALID=1, no new transfer starts. The timestamper keeps its capture, and later CAPT pulses are lost upstream by design.
- Total transfer: SCLK_DIV + 2*SCLK_DIV*WIDTH cycles with CE_N low. Defaults give 34 cycles.
- Boundary conditions:
  - ENABLE falls mid-transfer: the transfer completes through WAIT_CLR.
  - INT falls during SETUP/SHIFT: ignored; the transfer completes and the word is delivered.
  - Reset asserted mid-SHIFT: CE_N=1 and SCLK=0 immediately (async); partial sr discarded; no RSTCAPT issued.
  - TS_READY high in the same cycle TS_VALID rises: that word is not consumed until the next edge.
  - WIDTH=1: a single bit is shifted, with the same state sequence.
- bit_cnt width: $clog2(WIDTH)+1. Divider counter width: $clog2(SCLK_DIV)+1. Both wrap-free; they reset on state entry.

Decomposition:
- Package timestamp_reader_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, ARM, WAIT_CLR), default parameter constants.
- Sub-module sync2: 2-flop synchronizer with async active-low reset. Instanced for INT; reusable for other async CPLD lines.

Test Plan:
- Timestamper model preloaded with 0x0A, INT raised → CE_N low 2 edges later; exactly 8 SCLK rising edges; TS_DATA=0x0A, TS_VALID=1; RSTCAPT high 2 cycles after CE_N rises.
- Model value 0xA5 with TS_READY=0 held for 100 cycles; model reasserts INT with 0x3C → no CE_N activity and TS_DATA stays 0xA5. Raise TS_READY → TS_VALID drops, then the 0x3C read completes.
- RST_N pulsed low after the 3rd SCLK rise → CE_N=1 and SCLK=0 without waiting for a clock; TS_VALID=0, RSTCAPT never pulses. After release with INT still high, a full read returns the model value.
- ENABLE=0 with INT high → IDLE persists, BUSY=0. ENABLE dropped mid-SHIFT → word 0x81 still delivered and RSTCAPT still issued.
- Model keeps INT high for 5 cycles after RSTCAPT → reader stays in WAIT_CLR with no second transfer. INT later re-rises with 0x09 → TS_DATA=0x09.
- SCLK_DIV=3, WIDTH=12, value 0xABC → SCLK high and low phases each 3 cycles; CE_N low for 75 cycles; TS_DATA=0xABC.
